// File: rtl/dmem_bridge.sv
// dmem_bridge
//   Bridges the core's level-held load/store port onto a req/ack data memory
//   bus. Each access is captured once, held on the bus until ack, and
//   completed to the core with a one-cycle op_data_valid pulse.
//
//   Optional feature macro: DMEM_TIMEOUT_EN
//     defined   -> ack watchdog; a stuck access is forced to complete after
//                  TIMEOUT_CYCLES REQ cycles, loads return ERR_DATA and
//                  op_bus_error latches until reset.
//     undefined -> REQ waits for ack indefinitely; op_bus_error is tied 0.
//
//   state | meaning
//   ------+-------------------------------------------------------------
//   IDLE  | waiting for ip_data_wr/ip_data_rd; captures the access
//   REQ   | op_mem_req high, address/be/wdata/we held from capture regs
//   RESP  | op_data_valid high for this single cycle, then back to IDLE
module dmem_bridge #(
  parameter int unsigned TIMEOUT_CYCLES = 255,
  parameter logic [31:0] ERR_DATA       = 32'hDEADBEEF
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] ip_data_addr,
  input  logic        ip_data_wr,
  input  logic        ip_data_rd,
  input  logic [3:0]  ip_data_mask,
  input  logic [31:0] ip_data_from_proc,
  output logic        op_data_valid,
  output logic [31:0] op_data_to_proc,
  output logic        op_mem_req,
  output logic        op_mem_we,
  output logic [31:0] op_mem_addr,
  output logic [3:0]  op_mem_be,
  output logic [31:0] op_mem_wdata,
  input  logic        ip_mem_ack,
  input  logic [31:0] ip_mem_rdata,
  output logic        op_bus_error
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_RESP = 2'd2
  } state_t;

  state_t      state_q, state_d;
  logic [29:0] addr_q, addr_d;
  logic [3:0]  be_q, be_d;
  logic [31:0] wdata_q, wdata_d;
  logic        we_q, we_d;
  logic [31:0] rdata_q, rdata_d;

  // High in the REQ cycle where the watchdog gives up on the bus.
  logic        timeout_hit;

`ifdef DMEM_TIMEOUT_EN
  logic [7:0]  wait_cnt_q, wait_cnt_d;
  logic        err_q, err_d;

  // The limit is reached when this no-ack cycle would bring the count to
  // TIMEOUT_CYCLES; an ack in that same cycle takes precedence.
  assign timeout_hit = (state_q == ST_REQ) && !ip_mem_ack &&
                       (({1'b0, wait_cnt_q} + 9'd1) == 9'(TIMEOUT_CYCLES));

  // Wait counter clears on REQ entry and counts no-ack REQ cycles; error is sticky.
  always_comb begin
    wait_cnt_d = wait_cnt_q;
    err_d      = err_q | timeout_hit;
    if (state_q == ST_IDLE && (ip_data_wr || ip_data_rd)) begin
      wait_cnt_d = 8'd0;
    end else if (state_q == ST_REQ && !ip_mem_ack) begin
      wait_cnt_d = wait_cnt_q + 8'd1;
    end
  end

  // Watchdog registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wait_cnt_q <= 8'd0;
      err_q      <= 1'b0;
    end else begin
      wait_cnt_q <= wait_cnt_d;
      err_q      <= err_d;
    end
  end

  assign op_bus_error = err_q;

  logic unused_ok;
  assign unused_ok = ^ip_data_addr[1:0];
`else
  assign timeout_hit  = 1'b0;
  assign op_bus_error = 1'b0;

  // The watchdog limit and the byte offset within the word have no use here.
  logic unused_ok;
  assign unused_ok = ^{ip_data_addr[1:0], 8'(TIMEOUT_CYCLES)};
`endif

  // Next-state and capture logic for the access sequencer.
  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    be_d    = be_q;
    wdata_d = wdata_q;
    we_d    = we_q;
    rdata_d = rdata_q;
    case (state_q)
      ST_IDLE: begin
        if (ip_data_wr || ip_data_rd) begin
          addr_d  = ip_data_addr[31:2];
          be_d    = ip_data_mask;
          wdata_d = ip_data_from_proc;
          // A store wins when the core raises both strobes.
          we_d    = ip_data_wr;
          state_d = ST_REQ;
        end
      end
      ST_REQ: begin
        if (ip_mem_ack) begin
          if (!we_q) begin
            rdata_d = ip_mem_rdata;
          end
          state_d = ST_RESP;
        end else if (timeout_hit) begin
          if (!we_q) begin
            rdata_d = ERR_DATA;
          end
          state_d = ST_RESP;
        end
      end
      ST_RESP: begin
        // The core advances on the edge leaving RESP, so IDLE sees a fresh request.
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State and capture registers; reset abandons any in-flight access.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= ST_IDLE;
      addr_q  <= 30'd0;
      be_q    <= 4'd0;
      wdata_q <= 32'd0;
      we_q    <= 1'b0;
      rdata_q <= 32'd0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      be_q    <= be_d;
      wdata_q <= wdata_d;
      we_q    <= we_d;
      rdata_q <= rdata_d;
    end
  end

  assign op_mem_req      = (state_q == ST_REQ);
  assign op_data_valid   = (state_q == ST_RESP);
  assign op_mem_addr     = {addr_q, 2'b00};
  assign op_mem_be       = be_q;
  assign op_mem_wdata    = wdata_q;
  assign op_mem_we       = we_q;
  assign op_data_to_proc = rdata_q;

endmodule

// File: tb/tb_dmem_bridge.sv
// tb_dmem_bridge
//   Directed and randomized accesses against dmem_bridge. The expected bus
//   phase, latency and returned word come from a transaction-level model:
//   a read returns the acked word, a store leaves the last word in place,
//   and every access produces exactly one bus transfer and one valid pulse.
//   Build with DMEM_TIMEOUT_EN defined to also exercise the watchdog
//   (TIMEOUT_CYCLES is overridden to 4).
module tb_dmem_bridge;

  localparam int TO = 4;
`ifdef DMEM_TIMEOUT_EN
  localparam int MAXW = TO - 1;
`else
  localparam int MAXW = 6;
`endif

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [31:0] ip_data_addr = '0;
  logic        ip_data_wr = 1'b0;
  logic        ip_data_rd = 1'b0;
  logic [3:0]  ip_data_mask = '0;
  logic [31:0] ip_data_from_proc = '0;
  logic        op_data_valid;
  logic [31:0] op_data_to_proc;
  logic        op_mem_req;
  logic        op_mem_we;
  logic [31:0] op_mem_addr;
  logic [3:0]  op_mem_be;
  logic [31:0] op_mem_wdata;
  logic        ip_mem_ack = 1'b0;
  logic [31:0] ip_mem_rdata = '0;
  logic        op_bus_error;

  int errors = 0;
  int checks = 0;
  int bus_txn = 0;
  int model_txn = 0;
  logic [31:0] model_data = '0;

  dmem_bridge #(.TIMEOUT_CYCLES(TO), .ERR_DATA(32'hDEADBEEF)) dut (
    .clk(clk), .reset(reset),
    .ip_data_addr(ip_data_addr), .ip_data_wr(ip_data_wr), .ip_data_rd(ip_data_rd),
    .ip_data_mask(ip_data_mask), .ip_data_from_proc(ip_data_from_proc),
    .op_data_valid(op_data_valid), .op_data_to_proc(op_data_to_proc),
    .op_mem_req(op_mem_req), .op_mem_we(op_mem_we), .op_mem_addr(op_mem_addr),
    .op_mem_be(op_mem_be), .op_mem_wdata(op_mem_wdata),
    .ip_mem_ack(ip_mem_ack), .ip_mem_rdata(ip_mem_rdata),
    .op_bus_error(op_bus_error)
  );

  always #5 clk = ~clk;

  // Count completed bus transfers as seen on the bus itself.
  always @(posedge clk) if (op_mem_req && ip_mem_ack) bus_txn <= bus_txn + 1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic set_req(input logic [31:0] a, input logic w, input logic r,
                         input logic [3:0] m, input logic [31:0] d);
    ip_data_addr = a; ip_data_wr = w; ip_data_rd = r;
    ip_data_mask = m; ip_data_from_proc = d;
  endtask

  // One complete access: present on the cycle after the previous RESP,
  // ack after `waits` no-ack REQ cycles, hold the request through RESP.
  task automatic do_access(input logic [31:0] a, input logic w, input logic r,
                           input logic [3:0] m, input logic [31:0] d,
                           input int waits, input logic [31:0] rdata, input bit drop_mid);
    logic exp_we;
    exp_we = w;
    @(posedge clk); #1;
    set_req(a, w, r, m, d);
    @(negedge clk);
    chk("idle_req", {31'd0, op_mem_req}, 32'd0);
    chk("idle_valid", {31'd0, op_data_valid}, 32'd0);
    for (int n = 0; n <= waits; n++) begin
      @(negedge clk);
      chk("req_high", {31'd0, op_mem_req}, 32'd1);
      chk("req_valid_low", {31'd0, op_data_valid}, 32'd0);
      chk("mem_addr", op_mem_addr, {a[31:2], 2'b00});
      chk("mem_we", {31'd0, op_mem_we}, {31'd0, exp_we});
      chk("mem_be", {28'd0, op_mem_be}, {28'd0, m});
      chk("mem_wdata", op_mem_wdata, d);
      if (drop_mid) begin ip_data_wr = 1'b0; ip_data_rd = 1'b0; end
      if (n == waits) begin ip_mem_ack = 1'b1; ip_mem_rdata = rdata; end
      else begin ip_mem_ack = 1'b0; ip_mem_rdata = $urandom; end
    end
    @(negedge clk);
    ip_mem_ack = 1'b0; ip_mem_rdata = $urandom;
    if (!exp_we) model_data = rdata;
    model_txn++;
    chk("resp_req_low", {31'd0, op_mem_req}, 32'd0);
    chk("resp_valid", {31'd0, op_data_valid}, 32'd1);
    chk("resp_data", op_data_to_proc, model_data);
    chk("bus_error", {31'd0, op_bus_error}, 32'd0);
    chk("bus_txn_count", bus_txn, model_txn);
  endtask

  // Core idle after an access, with stray acks that must be ignored.
  task automatic idle(input int n);
    @(posedge clk); #1;
    set_req('0, 1'b0, 1'b0, '0, '0);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      chk("idle_req_low", {31'd0, op_mem_req}, 32'd0);
      chk("idle_no_valid", {31'd0, op_data_valid}, 32'd0);
      chk("idle_data_hold", op_data_to_proc, model_data);
      ip_mem_ack = 1'($urandom_range(0, 1));
      ip_mem_rdata = $urandom;
    end
    ip_mem_ack = 1'b0;
  endtask

  initial begin : stim
    logic [31:0] ra, rd_word, wd;
    logic        rw, rr;
    int          wt;

    #1;
    chk("rst_req", {31'd0, op_mem_req}, 32'd0);
    chk("rst_valid", {31'd0, op_data_valid}, 32'd0);
    chk("rst_data", op_data_to_proc, 32'd0);
    chk("rst_addr", op_mem_addr, 32'd0);
    chk("rst_be", {28'd0, op_mem_be}, 32'd0);
    chk("rst_wdata", op_mem_wdata, 32'd0);
    chk("rst_we", {31'd0, op_mem_we}, 32'd0);
    chk("rst_err", {31'd0, op_bus_error}, 32'd0);
    @(negedge clk); @(negedge clk);
    reset = 1'b1;

    // LW with two wait states, then SB with a zero-wait ack.
    do_access(32'h0000_0100, 1'b0, 1'b1, 4'hF, 32'h0, 2, 32'h1234_5678, 1'b0);
    idle(2);
    do_access(32'h0000_0203, 1'b1, 1'b0, 4'b1000, 32'hAB00_0000, 0, 32'h5A5A_5A5A, 1'b0);
    idle(1);

    // Back-to-back LW then SW.
    do_access(32'h0000_0400, 1'b0, 1'b1, 4'hF, 32'h0, 1, 32'hCAFE_F00D, 1'b0);
    do_access(32'h0000_0404, 1'b1, 1'b0, 4'hF, 32'h1122_3344, 0, 32'h7777_7777, 1'b0);

    // Both strobes -> one write; empty byte mask; request dropped mid-REQ.
    do_access(32'h0000_0508, 1'b1, 1'b1, 4'b0011, 32'h5555_AAAA, 1, 32'h9999_9999, 1'b0);
    do_access(32'h0000_0600, 1'b1, 1'b0, 4'b0000, 32'h0F0F_0F0F, 0, 32'h1, 1'b0);
    do_access(32'h0000_0700, 1'b0, 1'b1, 4'hF, 32'h0, 2, 32'h0BAD_F00D, 1'b1);
    idle(1);

    // Reset in the middle of REQ abandons the access.
    @(posedge clk); #1;
    set_req(32'h0000_0800, 1'b0, 1'b1, 4'hF, 32'h0);
    @(negedge clk);
    @(negedge clk);
    chk("mid_req_high", {31'd0, op_mem_req}, 32'd1);
    @(negedge clk);
    reset = 1'b0;
    #1;
    model_data = '0;
    chk("mid_rst_req", {31'd0, op_mem_req}, 32'd0);
    chk("mid_rst_valid", {31'd0, op_data_valid}, 32'd0);
    chk("mid_rst_data", op_data_to_proc, 32'd0);
    set_req('0, 1'b0, 1'b0, '0, '0);
    @(negedge clk);
    chk("mid_rst_no_valid", {31'd0, op_data_valid}, 32'd0);
    reset = 1'b1;
    do_access(32'h0000_0810, 1'b0, 1'b1, 4'hF, 32'h0, 1, 32'h0F1E_2D3C, 1'b0);

    // Random traffic.
    for (int k = 0; k < 24; k++) begin
      ra = $urandom;
      rw = 1'($urandom_range(0, 1));
      rr = rw ? 1'($urandom_range(0, 1)) : 1'b1;
      wd = $urandom;
      rd_word = $urandom;
      wt = $urandom_range(0, MAXW);
      do_access(ra, rw, rr, 4'($urandom_range(0, 15)), wd, wt, rd_word, ($urandom_range(0, 7) == 0));
      if ($urandom_range(0, 1) == 1) idle($urandom_range(1, 3));
    end

`ifdef DMEM_TIMEOUT_EN
    // Ack exactly on the limit cycle completes normally.
    do_access(32'h0000_0900, 1'b0, 1'b1, 4'hF, 32'h0, TO - 1, 32'h2468_ACE0, 1'b0);
    idle(1);
    // No ack at all: forced completion with error data.
    @(posedge clk); #1;
    set_req(32'h0000_0A00, 1'b0, 1'b1, 4'hF, 32'h0);
    @(negedge clk);
    for (int n = 0; n < TO; n++) begin
      @(negedge clk);
      chk("to_req_high", {31'd0, op_mem_req}, 32'd1);
    end
    @(negedge clk);
    model_data = 32'hDEADBEEF;
    chk("to_req_low", {31'd0, op_mem_req}, 32'd0);
    chk("to_valid", {31'd0, op_data_valid}, 32'd1);
    chk("to_data", op_data_to_proc, model_data);
    chk("to_err", {31'd0, op_bus_error}, 32'd1);
    idle(3);
    chk("to_err_sticky", {31'd0, op_bus_error}, 32'd1);
    chk("to_txn_count", bus_txn, model_txn);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin : watchdog
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d checks=%0d", errors, checks);
    $fatal(1, "watchdog expired");
  end

endmodule
